// File: rtl/cmd_assembler.sv
// -----------------------------------------------------------------------------
// cmd_assembler
//   Collects raw UART RX bytes into complete SUMP/OLS commands.
//   Short commands (opcode[7]=0) are one byte. Long commands (opcode[7]=1) are
//   the opcode byte followed by four payload bytes, with the first payload byte
//   landing in cmd_o[31:24]. A stalled long command is dropped after
//   TIMEOUT_CYCLES idle cycles. A run of SOFT_RST_CNT consecutive 0x00 short
//   opcodes raises soft_rst_o.
//
// Handshake: rx_stb_i is a one-cycle qualifier for rx_data_i. There is no
//   back-pressure, so every strobe is consumed in the cycle it is seen,
//   including strobes on consecutive cycles.
//
// Ports
//   clk_i       in   system clock (rising edge)
//   rst_in      in   asynchronous active-low reset
//   rx_data_i   in   [7:0] received byte, qualified by rx_stb_i
//   rx_stb_i    in   new-byte strobe
//   opcode_o    out  [7:0] opcode of the last completed command
//   cmd_o       out  [31:0] payload of the last completed command (0 if short)
//   exe_o       out  one-cycle pulse, opcode_o/cmd_o valid
//   busy_o      out  long command partially received
//   timeout_o   out  one-cycle pulse, partial long command discarded
//   soft_rst_o  out  one-cycle pulse, SOFT_RST_CNT consecutive 0x00 opcodes
//   state_o     out  debug view of the FSM state (0=IDLE, 1=PAYLOAD)
// -----------------------------------------------------------------------------
module cmd_assembler #(
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int SOFT_RST_CNT   = 5
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_stb_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] cmd_o,
  output logic        exe_o,
  output logic        busy_o,
  output logic        timeout_o,
  output logic        soft_rst_o,
  output logic [0:0]  state_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam int SR_W = $clog2(SOFT_RST_CNT + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic [0:0]      state_q;
  logic [1:0]      idx_q;      // payload bytes already taken (0..3)
  logic [23:0]     sr_q;       // first three payload bytes; the fourth comes straight from rx_data_i
  logic [7:0]      op_q;       // latched opcode of the long command in progress
  logic [TO_W-1:0] to_cnt_q;
  logic [SR_W-1:0] zero_cnt_q;

  assign busy_o  = (state_q == PAYLOAD);
  assign state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sr_q       <= '0;
      op_q       <= '0;
      to_cnt_q   <= '0;
      zero_cnt_q <= '0;
      opcode_o   <= '0;
      cmd_o      <= '0;
      exe_o      <= 1'b0;
      timeout_o  <= 1'b0;
      soft_rst_o <= 1'b0;
    end else begin
      exe_o      <= 1'b0;
      timeout_o  <= 1'b0;
      soft_rst_o <= 1'b0;

      if (state_q == IDLE) begin
        to_cnt_q <= '0;
        if (rx_stb_i) begin
          op_q <= rx_data_i;
          if (!rx_data_i[7]) begin
            exe_o    <= 1'b1;
            opcode_o <= rx_data_i;
            cmd_o    <= '0;
            // Only short commands touch the 0x00 run counter.
            if (rx_data_i == 8'h00) begin
              if (zero_cnt_q >= SR_W'(SOFT_RST_CNT - 1)) begin
                soft_rst_o <= 1'b1;
                zero_cnt_q <= '0;
              end else begin
                zero_cnt_q <= zero_cnt_q + SR_W'(1);
              end
            end else begin
              zero_cnt_q <= '0;
            end
          end else begin
            state_q <= PAYLOAD;
            idx_q   <= '0;
            sr_q    <= '0;
          end
        end
      end else begin
        // A strobe in the expiry cycle takes priority over the timeout.
        if (rx_stb_i) begin
          to_cnt_q <= '0;
          sr_q     <= {sr_q[15:0], rx_data_i};
          idx_q    <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_q  <= IDLE;
            exe_o    <= 1'b1;
            opcode_o <= op_q;
            cmd_o    <= {sr_q, rx_data_i};
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_q   <= IDLE;
          timeout_o <= 1'b1;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_assembler.sv
module tb_cmd_assembler;

  localparam int TIMEOUT = 20;
  localparam int SOFT    = 5;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_stb_i = 1'b0;
  logic [7:0]  opcode_o;
  logic [31:0] cmd_o;
  logic        exe_o, busy_o, timeout_o, soft_rst_o;
  logic [0:0]  state_o;

  always #5 clk_i = ~clk_i;

  cmd_assembler #(.TIMEOUT_CYCLES(TIMEOUT), .SOFT_RST_CNT(SOFT)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .rx_data_i(rx_data_i), .rx_stb_i(rx_stb_i),
    .opcode_o(opcode_o), .cmd_o(cmd_o), .exe_o(exe_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .soft_rst_o(soft_rst_o), .state_o(state_o)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [43:0] exp_q[$];
  int exe_seen, to_seen, sr_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [43:0] dut_outs();
    return {exe_o, timeout_o, soft_rst_o, busy_o, opcode_o, cmd_o};
  endfunction

  // ---------------- reference model ----------------
  // Command-level view: bytes of the pending long command in a queue,
  // idle-cycle count since the last byte, and the length of the 0x00 run.
  logic [7:0]  part_q[$];
  int          idle_n;
  int          zero_run;
  logic [7:0]  m_op;
  logic [31:0] m_cmd;

  task automatic model_reset();
    part_q.delete();
    idle_n = 0; zero_run = 0; m_op = 8'h00; m_cmd = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic stb, input logic [7:0] d, output logic [43:0] e);
    logic ex, to, sr;
    ex = 1'b0; to = 1'b0; sr = 1'b0;
    if (part_q.size() == 0) begin
      if (stb) begin
        if (d < 8'h80) begin
          ex = 1'b1; m_op = d; m_cmd = 32'h0;
          if (d == 8'h00) begin
            zero_run++;
            if (zero_run == SOFT) begin sr = 1'b1; zero_run = 0; end
          end else zero_run = 0;
        end else begin
          part_q.push_back(d); idle_n = 0;
        end
      end
    end else begin
      if (stb) begin
        part_q.push_back(d); idle_n = 0;
        if (part_q.size() == 5) begin
          ex = 1'b1; m_op = part_q[0];
          m_cmd = {part_q[1], part_q[2], part_q[3], part_q[4]};
          part_q.delete();
        end
      end else begin
        idle_n++;
        if (idle_n == TIMEOUT) begin to = 1'b1; part_q.delete(); end
      end
    end
    e = {ex, to, sr, (part_q.size() != 0), m_op, m_cmd};
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input logic stb, input logic [7:0] d);
    logic [43:0] e;
    @(negedge clk_i);
    rx_stb_i = stb; rx_data_i = d;
    model_step(stb, d, e);
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    check("cycle_outputs", 64'(dut_outs()), 64'(exp_q.pop_front()));
    exe_seen += int'(exe_o); to_seen += int'(timeout_o); sr_seen += int'(soft_rst_o);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_in = 1'b0; rx_stb_i = 1'b0;
    #2;
    check("reset_outputs", 64'(dut_outs()), 64'h0);
    model_reset();
    @(negedge clk_i);
    rst_in = 1'b1;
  endtask

  task automatic clr_seen();
    exe_seen = 0; to_seen = 0; sr_seen = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] pay;
    logic [7:0]  exp_op;
    logic [31:0] exp_cmd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 8'h02, pay: 32'hDEADBEEF, exp_op: 8'h02, exp_cmd: 32'h0};
    vecs[1] = '{op: 8'h81, pay: 32'h10203040, exp_op: 8'h81, exp_cmd: 32'h10203040};
    vecs[2] = '{op: 8'hFF, pay: 32'h80FF0001, exp_op: 8'hFF, exp_cmd: 32'h80FF0001};
    vecs[3] = '{op: 8'h7F, pay: 32'h12345678, exp_op: 8'h7F, exp_cmd: 32'h0};
    vecs[4] = '{op: 8'hC2, pay: 32'h00000000, exp_op: 8'hC2, exp_cmd: 32'h0};
    vecs[5] = '{op: 8'h11, pay: 32'hFFFFFFFF, exp_op: 8'h11, exp_cmd: 32'h0};

    model_reset();
    clr_seen();
    rst_in = 1'b0;
    #12;
    check("reset_state", 64'(dut_outs()), 64'h0);
    do_reset();

    // Table-driven commands, back-to-back strobes.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, vecs[i].op);
      if (vecs[i].op[7]) begin
        check($sformatf("vec%0d_busy", i), 64'(busy_o), 64'd1);
        for (int k = 3; k >= 0; k--) cycle(1'b1, vecs[i].pay[k*8 +: 8]);
      end
      check($sformatf("vec%0d_result", i), {23'h0, exe_o, opcode_o, cmd_o},
            {23'h0, 1'b1, vecs[i].exp_op, vecs[i].exp_cmd});
    end
    cycle(1'b0, 8'h00);

    // Timeout discards the partial command, then resync on a short opcode.
    clr_seen();
    cycle(1'b1, 8'hC0); cycle(1'b1, 8'hAA); cycle(1'b1, 8'hBB);
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 8'h5A);
    check("t3_timeout_pulses", 64'(to_seen), 64'd1);
    check("t3_no_exe", 64'(exe_seen), 64'd0);
    check("t3_busy_cleared", 64'(busy_o), 64'd0);
    cycle(1'b1, 8'h01);
    check("t3_resync", {55'h0, exe_o, opcode_o}, {55'h0, 1'b1, 8'h01});

    // Strobe in the expiry cycle wins over the timeout.
    clr_seen();
    cycle(1'b1, 8'h90);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA1);
    for (int i = 0; i < TIMEOUT - 1; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'hA2); cycle(1'b1, 8'hA3); cycle(1'b1, 8'hA4);
    check("expiry_race_no_timeout", 64'(to_seen), 64'd0);
    check("expiry_race_cmd", {24'h0, exe_o, timeout_o, opcode_o, cmd_o},
          {24'h0, 1'b1, 1'b0, 8'h90, 32'hA1A2A3A4});

    // Soft reset on the fifth consecutive 0x00.
    clr_seen();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00);
    check("t4_no_early_sr", 64'(sr_seen), 64'd0);
    cycle(1'b1, 8'h00);
    check("t4_sr_on_fifth", {62'h0, exe_o, soft_rst_o}, {62'h0, 1'b1, 1'b1});
    check("t4_exe_count", 64'(exe_seen), 64'd5);
    clr_seen();
    cycle(1'b1, 8'h00); cycle(1'b1, 8'h00); cycle(1'b1, 8'h11); cycle(1'b1, 8'h00);
    check("t4_broken_run", 64'(sr_seen), 64'd0);

    // 0x00 payload bytes do not count and do not disturb the run (now at 1).
    clr_seen();
    cycle(1'b1, 8'h80);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h00);
    check("t5_cmd", {23'h0, exe_o, opcode_o, cmd_o}, {23'h0, 1'b1, 8'h80, 32'h0});
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h00);
    check("t5_no_sr_yet", 64'(sr_seen), 64'd0);
    cycle(1'b1, 8'h00);
    check("t5_sr_after_payload", 64'(soft_rst_o), 64'd1);
    cycle(1'b0, 8'h00);

    // Reset in the middle of a long command.
    cycle(1'b1, 8'h82); cycle(1'b1, 8'h01);
    do_reset();
    cycle(1'b1, 8'h82); cycle(1'b1, 8'h01); cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03); cycle(1'b1, 8'h04);
    check("t6_cmd", {23'h0, exe_o, opcode_o, cmd_o}, {23'h0, 1'b1, 8'h82, 32'h01020304});
    cycle(1'b0, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      int unsigned g;
      int gap;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 25) b = 8'h00;
      else if (r < 45) b = 8'($urandom_range(128, 255));
      else b = 8'($urandom_range(0, 255));
      if (r == 99) do_reset();
      cycle(1'b1, b);
      g = $urandom_range(0, 19);
      if (g < 12) gap = 0;
      else if (g < 18) gap = int'($urandom_range(1, 3));
      else gap = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
      for (int k = 0; k < gap; k++) cycle(1'b0, 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
